// File: rtl/axi4_pkg.sv
// Shared AXI4 read-channel types and constants for the round-robin read arbiter.
package axi4_pkg;

  localparam int AXI4_MAX_BEATS = 256;
  localparam int AXI4_ID_W      = 4;
  localparam int AXI4_ADDR_W    = 32;
  localparam int AXI4_DATA_W    = 32;

  typedef enum logic [1:0] {ARB_IDLE, ARB_ADDR, ARB_DATA} arb_state_e;

  typedef struct packed {
    logic [AXI4_ID_W-1:0]   id;
    logic [AXI4_ADDR_W-1:0] addr;
    logic [7:0]             len;
    logic [2:0]             size;
    logic [1:0]             burst;
    logic                   valid;
  } ar_m;

  typedef struct packed {
    logic ready;
  } ar_s;

  typedef struct packed {
    logic ready;
  } r_m;

  typedef struct packed {
    logic [AXI4_ID_W-1:0]   id;
    logic [AXI4_DATA_W-1:0] data;
    logic [1:0]             resp;
    logic                   last;
    logic                   valid;
  } r_s;

endpackage

// File: rtl/axi4_assert.sv
// Protocol checker for one AXI4 read port (AR/R); bound on the slave side and each master side.
module axi4_assert
  import axi4_pkg::*;
(
  input logic clk,
  input logic rst_n,
  input ar_m  ar,
  input ar_s  ar_rdy,
  input r_s   r,
  input r_m   r_rdy
);

  // Once raised, ARVALID and its payload must stay put until accepted.
  ar_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (ar.valid && !ar_rdy.ready) |=>
      (ar.valid && $stable(ar.addr) && $stable(ar.len) && $stable(ar.id)));

  handshake_known: assert property (@(posedge clk) disable iff (!rst_n)
    !$isunknown({ar.valid, ar_rdy.ready, r.valid, r_rdy.ready}));

  ar_payload_known: assert property (@(posedge clk) disable iff (!rst_n)
    ar.valid |-> !$isunknown(ar));

  r_payload_known: assert property (@(posedge clk) disable iff (!rst_n)
    r.valid |-> !$isunknown(r));

endmodule

// File: rtl/axi4_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr, wrapping mod NUM_M.
module axi4_rr_pick #(
  parameter  int NUM_M = 2,
  localparam int GW    = $clog2(NUM_M)
) (
  input  logic [NUM_M-1:0] req,
  input  logic [GW-1:0]    ptr,
  output logic             valid,
  output logic [GW-1:0]    idx
);

  logic [GW-1:0] cand;

  // Scan offsets from farthest to nearest so the nearest requester is written last and wins.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int i = NUM_M - 1; i >= 0; i--) begin
      cand = GW'((int'(ptr) + i) % NUM_M);
      if (req[cand]) begin
        valid = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/axi4_rd_arbiter.sv
// Round-robin arbiter sharing one AXI4 slave read port among NUM_M masters, one burst at a time,
// with a sticky flag for bursts whose RLAST beat count disagrees with ARLEN.
module axi4_rd_arbiter
  import axi4_pkg::*;
#(
  parameter  int NUM_M = 2,
  localparam int GW    = $clog2(NUM_M)
) (
  input  logic          ACLK,
  input  logic          ARESETn,
  input  ar_m           AXI_AR_M_IN  [NUM_M],
  output ar_s           AXI_AR_S_OUT [NUM_M],
  input  r_m            AXI_R_M_IN   [NUM_M],
  output r_s            AXI_R_S_OUT  [NUM_M],
  output ar_m           AXI_AR_M_OUT,
  input  ar_s           AXI_AR_S_IN,
  output r_m            AXI_R_M_OUT,
  input  r_s            AXI_R_S_IN,
  output logic          BUSY,
  output logic [GW-1:0] GRANT,
  output logic          LEN_ERR
);

  arb_state_e    state, state_d;
  logic [GW-1:0] grant, grant_d;
  logic [GW-1:0] rr_ptr, rr_ptr_d;
  logic [8:0]    beat_cnt, beat_d;
  logic [7:0]    len_q, len_d;
  logic          len_err, err_d;

  logic [NUM_M-1:0] req;
  logic             pick_valid;
  logic [GW-1:0]    pick_idx;

  always_comb begin
    req = '0;
    for (int i = 0; i < NUM_M; i++) begin
      req[i] = AXI_AR_M_IN[i].valid;
    end
  end

  axi4_rr_pick #(.NUM_M(NUM_M)) u_pick (
    .req   (req),
    .ptr   (rr_ptr),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state    <= ARB_IDLE;
      grant    <= '0;
      rr_ptr   <= '0;
      beat_cnt <= '0;
      len_q    <= '0;
      len_err  <= 1'b0;
    end else begin
      state    <= state_d;
      grant    <= grant_d;
      rr_ptr   <= rr_ptr_d;
      beat_cnt <= beat_d;
      len_q    <= len_d;
      len_err  <= err_d;
    end
  end

  // Channels are routed only for the granted master and only in the phase that owns them;
  // everything else sits at zero, which also keeps stray slave beats out of IDLE.
  always_comb begin
    state_d      = state;
    grant_d      = grant;
    rr_ptr_d     = rr_ptr;
    beat_d       = beat_cnt;
    len_d        = len_q;
    err_d        = len_err;
    AXI_AR_M_OUT = '0;
    AXI_R_M_OUT  = '0;
    for (int i = 0; i < NUM_M; i++) begin
      AXI_AR_S_OUT[i] = '0;
      AXI_R_S_OUT[i]  = '0;
    end

    case (state)
      ARB_IDLE: begin
        if (pick_valid) begin
          grant_d = pick_idx;
          state_d = ARB_ADDR;
        end
      end

      ARB_ADDR: begin
        AXI_AR_M_OUT        = AXI_AR_M_IN[grant];
        AXI_AR_S_OUT[grant] = AXI_AR_S_IN;
        if (AXI_AR_M_IN[grant].valid && AXI_AR_S_IN.ready) begin
          len_d   = AXI_AR_M_IN[grant].len;
          beat_d  = '0;
          state_d = ARB_DATA;
        end
      end

      ARB_DATA: begin
        AXI_R_S_OUT[grant] = AXI_R_S_IN;
        AXI_R_M_OUT        = AXI_R_M_IN[grant];
        if (AXI_R_S_IN.valid && AXI_R_M_IN[grant].ready) begin
          if (beat_cnt != 9'(AXI4_MAX_BEATS)) begin
            beat_d = beat_cnt + 9'd1;
          end
          if (AXI_R_S_IN.last) begin
            if (({1'b0, beat_cnt} + 10'd1) != ({2'b00, len_q} + 10'd1)) begin
              err_d = 1'b1;
            end
            rr_ptr_d = (grant == GW'(NUM_M - 1)) ? '0 : grant + GW'(1);
            state_d  = ARB_IDLE;
          end
        end
      end

      default: state_d = ARB_IDLE;
    endcase
  end

  assign BUSY    = (state != ARB_IDLE);
  assign GRANT   = grant;
  assign LEN_ERR = len_err;

endmodule

// File: tb/tb_axi4_rd_arbiter.sv
// Directed self-checking bench for axi4_rd_arbiter with three masters and a hand-driven slave.
module tb_axi4_rd_arbiter;
  import axi4_pkg::*;

  logic       ACLK;
  logic       ARESETn;
  ar_m        ar_m_in  [3];
  ar_s        ar_s_out [3];
  r_m         r_m_in   [3];
  r_s         r_s_out  [3];
  ar_m        ar_m_out;
  ar_s        ar_s_in;
  r_m         r_m_out;
  r_s         r_s_in;
  logic       busy;
  logic [1:0] grant;
  logic       len_err;

  int checks;
  int errors;
  int exp_order [6];

  axi4_rd_arbiter #(.NUM_M(3)) dut (
    .ACLK         (ACLK),
    .ARESETn      (ARESETn),
    .AXI_AR_M_IN  (ar_m_in),
    .AXI_AR_S_OUT (ar_s_out),
    .AXI_R_M_IN   (r_m_in),
    .AXI_R_S_OUT  (r_s_out),
    .AXI_AR_M_OUT (ar_m_out),
    .AXI_AR_S_IN  (ar_s_in),
    .AXI_R_M_OUT  (r_m_out),
    .AXI_R_S_IN   (r_s_in),
    .BUSY         (busy),
    .GRANT        (grant),
    .LEN_ERR      (len_err)
  );

  axi4_assert u_slave_chk (
    .clk    (ACLK),
    .rst_n  (ARESETn),
    .ar     (ar_m_out),
    .ar_rdy (ar_s_in),
    .r      (r_s_in),
    .r_rdy  (r_m_out)
  );

  for (genvar g = 0; g < 3; g++) begin : g_master_chk
    axi4_assert u_chk (
      .clk    (ACLK),
      .rst_n  (ARESETn),
      .ar     (ar_m_in[g]),
      .ar_rdy (ar_s_out[g]),
      .r      (r_s_out[g]),
      .r_rdy  (r_m_in[g])
    );
  end

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic apply_reset();
    ARESETn = 1'b0;
    tick();
    check_output("rst_busy", 32'(busy), 32'd0);
    check_output("rst_grant", 32'(grant), 32'd0);
    check_output("rst_len_err", 32'(len_err), 32'd0);
    check_output("rst_slave_arvalid", 32'(ar_m_out.valid), 32'd0);
    check_output("rst_slave_rready", 32'(r_m_out.ready), 32'd0);
    tick();
    ARESETn = 1'b1;
  endtask

  task automatic raise_ar(input int m, input int len);
    ar_m_in[m].id    = 4'(m);
    ar_m_in[m].addr  = 32'h1000_0000 + 32'(m) * 32'h100;
    ar_m_in[m].len   = 8'(len);
    ar_m_in[m].size  = 3'd2;
    ar_m_in[m].burst = 2'b01;
    ar_m_in[m].valid = 1'b1;
  endtask

  task automatic run_beats(input int m, input int n);
    logic [31:0] exp_data;
    r_m_in[m].ready = 1'b1;
    for (int k = 0; k < n; k++) begin
      exp_data      = 32'hA000_0000 + 32'(m << 8) + 32'(k);
      r_s_in.valid  = 1'b1;
      r_s_in.data   = exp_data;
      r_s_in.last   = (k == n - 1);
      r_s_in.id     = 4'(m);
      r_s_in.resp   = 2'b00;
      settle();
      check_output("beat_rvalid", 32'(r_s_out[m].valid), 32'd1);
      check_output("beat_rdata", r_s_out[m].data, exp_data);
      check_output("beat_rready", 32'(r_m_out.ready), 32'd1);
      for (int j = 0; j < 3; j++) begin
        if (j != m) check_output("beat_other_rvalid", 32'(r_s_out[j].valid), 32'd0);
      end
      tick();
    end
    r_s_in          = '0;
    r_m_in[m].ready = 1'b0;
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    exp_order = '{0, 1, 2, 0, 1, 2};
    ARESETn = 1'b0;
    ar_s_in = '0;
    r_s_in  = '0;
    for (int i = 0; i < 3; i++) begin
      ar_m_in[i] = '0;
      r_m_in[i]  = '0;
    end

    // Single 4-beat burst from M0, with one cycle of slave ARREADY backpressure.
    apply_reset();
    raise_ar(0, 3);
    ar_s_in.ready = 1'b0;
    settle();
    check_output("idle_no_arready", 32'(ar_s_out[0].ready), 32'd0);
    check_output("idle_no_arvalid", 32'(ar_m_out.valid), 32'd0);
    check_output("idle_busy", 32'(busy), 32'd0);
    tick();
    check_output("addr_busy", 32'(busy), 32'd1);
    check_output("addr_grant", 32'(grant), 32'd0);
    check_output("addr_arvalid", 32'(ar_m_out.valid), 32'd1);
    check_output("addr_arlen", 32'(ar_m_out.len), 32'd3);
    check_output("addr_araddr", ar_m_out.addr, 32'h1000_0000);
    check_output("addr_arready_held", 32'(ar_s_out[0].ready), 32'd0);
    tick();
    ar_s_in.ready = 1'b1;
    settle();
    check_output("addr_wait_arvalid", 32'(ar_m_out.valid), 32'd1);
    check_output("addr_arready_pass", 32'(ar_s_out[0].ready), 32'd1);
    tick();
    ar_m_in[0].valid = 1'b0;
    settle();
    check_output("data_busy", 32'(busy), 32'd1);
    check_output("data_no_arvalid", 32'(ar_m_out.valid), 32'd0);
    run_beats(0, 4);
    settle();
    check_output("t1_done_busy", 32'(busy), 32'd0);
    check_output("t1_len_err", 32'(len_err), 32'd0);
    check_output("t1_m0_rvalid", 32'(r_s_out[0].valid), 32'd0);

    // M0 and M1 contend with rr_ptr=0; M1 waits, then is granted; M1 stalls RREADY.
    apply_reset();
    raise_ar(0, 0);
    raise_ar(1, 0);
    settle();
    tick();
    check_output("cont_grant0", 32'(grant), 32'd0);
    check_output("cont_m0_arready", 32'(ar_s_out[0].ready), 32'd1);
    check_output("cont_m1_arready_a", 32'(ar_s_out[1].ready), 32'd0);
    tick();
    ar_m_in[0].valid = 1'b0;
    settle();
    check_output("cont_m1_arready_b", 32'(ar_s_out[1].ready), 32'd0);
    run_beats(0, 1);
    settle();
    check_output("gap_busy", 32'(busy), 32'd0);
    check_output("gap_no_arvalid", 32'(ar_m_out.valid), 32'd0);
    check_output("gap_m1_arready", 32'(ar_s_out[1].ready), 32'd0);
    tick();
    check_output("cont_grant1", 32'(grant), 32'd1);
    check_output("cont_m1_arready_c", 32'(ar_s_out[1].ready), 32'd1);
    tick();
    ar_m_in[1].valid = 1'b0;
    r_m_in[1].ready  = 1'b0;
    r_s_in.valid     = 1'b1;
    r_s_in.data      = 32'hDEAD_BEEF;
    r_s_in.last      = 1'b1;
    r_s_in.id        = 4'd1;
    for (int c = 0; c < 3; c++) begin
      settle();
      check_output("stall_rvalid", 32'(r_s_out[1].valid), 32'd1);
      check_output("stall_rdata", r_s_out[1].data, 32'hDEAD_BEEF);
      check_output("stall_m0_rvalid", 32'(r_s_out[0].valid), 32'd0);
      check_output("stall_rready", 32'(r_m_out.ready), 32'd0);
      check_output("stall_busy", 32'(busy), 32'd1);
      tick();
    end
    r_m_in[1].ready = 1'b1;
    settle();
    check_output("stall_release_rready", 32'(r_m_out.ready), 32'd1);
    tick();
    r_s_in          = '0;
    r_m_in[1].ready = 1'b0;
    settle();
    check_output("stall_done_busy", 32'(busy), 32'd0);
    check_output("stall_len_err", 32'(len_err), 32'd0);

    // Second contention (rr_ptr=2) grants M0 again, then M1.
    raise_ar(0, 0);
    raise_ar(1, 0);
    tick();
    check_output("cont2_grant0", 32'(grant), 32'd0);
    tick();
    ar_m_in[0].valid = 1'b0;
    run_beats(0, 1);
    tick();
    check_output("cont2_grant1", 32'(grant), 32'd1);
    tick();
    ar_m_in[1].valid = 1'b0;
    run_beats(1, 1);

    // ARLEN=7 but RLAST on beat 5: sticky LEN_ERR survives a later good burst.
    raise_ar(0, 7);
    tick();
    check_output("lenerr_grant", 32'(grant), 32'd0);
    tick();
    ar_m_in[0].valid = 1'b0;
    run_beats(0, 5);
    settle();
    check_output("lenerr_set", 32'(len_err), 32'd1);
    raise_ar(1, 1);
    tick();
    check_output("lenerr_next_grant", 32'(grant), 32'd1);
    tick();
    ar_m_in[1].valid = 1'b0;
    run_beats(1, 2);
    settle();
    check_output("lenerr_sticky", 32'(len_err), 32'd1);

    // Reset pulse on beat 2 of 4; stray slave beat afterwards is not forwarded.
    raise_ar(0, 3);
    tick();
    check_output("rstmid_grant", 32'(grant), 32'd0);
    tick();
    ar_m_in[0].valid = 1'b0;
    r_m_in[0].ready  = 1'b1;
    r_s_in.valid     = 1'b1;
    r_s_in.data      = 32'h0000_0B01;
    r_s_in.last      = 1'b0;
    tick();
    r_s_in.data = 32'h0000_0B02;
    settle();
    check_output("rstmid_pre_rvalid", 32'(r_s_out[0].valid), 32'd1);
    ARESETn = 1'b0;
    settle();
    check_output("rstmid_busy", 32'(busy), 32'd0);
    check_output("rstmid_grant0", 32'(grant), 32'd0);
    check_output("rstmid_len_err", 32'(len_err), 32'd0);
    check_output("rstmid_arvalid", 32'(ar_m_out.valid), 32'd0);
    check_output("rstmid_rready", 32'(r_m_out.ready), 32'd0);
    check_output("rstmid_m0_rvalid", 32'(r_s_out[0].valid), 32'd0);
    check_output("rstmid_m0_rdata", r_s_out[0].data, 32'd0);
    tick();
    ARESETn = 1'b1;
    settle();
    check_output("stray_rready", 32'(r_m_out.ready), 32'd0);
    check_output("stray_m0_rvalid", 32'(r_s_out[0].valid), 32'd0);
    tick();
    check_output("stray_busy", 32'(busy), 32'd0);
    check_output("stray_m0_rvalid2", 32'(r_s_out[0].valid), 32'd0);
    r_s_in          = '0;
    r_m_in[0].ready = 1'b0;
    raise_ar(1, 0);
    tick();
    check_output("fresh_grant", 32'(grant), 32'd1);
    tick();
    ar_m_in[1].valid = 1'b0;
    run_beats(1, 1);
    settle();
    check_output("fresh_busy", 32'(busy), 32'd0);
    check_output("fresh_len_err", 32'(len_err), 32'd0);

    // All three masters requesting continuously: grant order 0,1,2,0,1,2.
    apply_reset();
    raise_ar(0, 0);
    raise_ar(1, 0);
    raise_ar(2, 0);
    for (int i = 0; i < 6; i++) begin
      tick();
      check_output("rr_order", 32'(grant), 32'(exp_order[i]));
      tick();
      run_beats(exp_order[i], 1);
    end

    ARESETn = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ar_m_in[i] = '0;
    end
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
